// File: rtl/minimac3_rxq_if.sv
// minimac3_rxq_if: engine/host handshake bundle for the receive slot queue.
// slave modport is the queue itself; master modport is the engine+host side.
interface minimac3_rxq_if #(
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned COUNT_W = 11
);
    // RX engine side
    logic               eng_req;
    logic               eng_grant;
    logic [IDX_W-1:0]   eng_slot;
    logic               eng_done;
    logic [COUNT_W-1:0] eng_count;
    logic               eng_abort;

    // Host side
    logic               host_valid;
    logic [IDX_W-1:0]   host_slot;
    logic [COUNT_W-1:0] host_count;
    logic               host_ack;

    // Status
    logic               irq_rx;
    logic [IDX_W:0]     free_count;
    logic [15:0]        drop_cnt;

    modport slave (
        input  eng_req, eng_done, eng_count, eng_abort, host_ack,
        output eng_grant, eng_slot, host_valid, host_slot, host_count,
               irq_rx, free_count, drop_cnt
    );

    modport master (
        output eng_req, eng_done, eng_count, eng_abort, host_ack,
        input  eng_grant, eng_slot, host_valid, host_slot, host_count,
               irq_rx, free_count, drop_cnt
    );
endinterface

// File: rtl/minimac3_rxq.sv
// minimac3_rxq: receive buffer slot allocator with in-order completion FIFO.
// Each slot is FREE, OWNED (filled by the RX engine) or QUEUED (waiting for
// the host). Optional drop statistics counter is built when
// MINIMAC3_RXQ_STATS_EN is defined; otherwise drop_cnt is tied to zero.
module minimac3_rxq #(
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned COUNT_W = 11,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    minimac3_rxq_if.slave        bus
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_OWNED  = 2'd1,
        SLOT_QUEUED = 2'd2
    } slot_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } eng_state_e;

    typedef struct packed {
        logic [IDX_W-1:0]   slot;
        logic [COUNT_W-1:0] count;
    } entry_t;

    // Registered state
    eng_state_e         state_q;
    slot_e              slot_q [SLOTS];
    logic               eng_grant_q;
    logic [IDX_W-1:0]   eng_slot_q;
    entry_t             fifo_mem [SLOTS];
    logic [IDX_W-1:0]   rd_ptr_q;
    logic [IDX_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;
    logic               host_valid_q;
    logic [IDX_W-1:0]   host_slot_q;
    logic [COUNT_W-1:0] host_count_q;
    logic [CNT_W-1:0]   free_count_q;

    // Combinational events and next values
    logic [IDX_W-1:0]   free_idx_c;
    logic               grant_c;
    logic               push_c;
    logic               abort_c;
    logic               pop_c;
    entry_t             push_entry_c;
    logic [IDX_W-1:0]   rd_ptr_n;
    logic [IDX_W-1:0]   wr_ptr_n;
    logic [CNT_W-1:0]   fifo_cnt_n;
    logic [CNT_W-1:0]   remain_c;
    entry_t             head_n;
    logic [CNT_W-1:0]   free_count_n;

    // Pointer advance modulo SLOTS (works for non power-of-two SLOTS)
    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        if (p == IDX_W'(SLOTS - 1)) begin
            return '0;
        end
        return p + IDX_W'(1);
    endfunction

    // Lowest-indexed FREE slot; descending scan so the lowest match wins
    always_comb begin
        free_idx_c = '0;
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_FREE) begin
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // Engine and host events; abort wins over done, ack ignored when empty
    always_comb begin
        grant_c      = (state_q == ST_IDLE) && bus.eng_req && (free_count_q != '0);
        abort_c      = (state_q == ST_OWN) && bus.eng_abort;
        push_c       = (state_q == ST_OWN) && bus.eng_done && !bus.eng_abort;
        pop_c        = bus.host_ack && host_valid_q;
        push_entry_c = '{slot: eng_slot_q, count: bus.eng_count};
    end

    // FIFO next-state and registered head lookahead
    always_comb begin
        rd_ptr_n   = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_n   = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        fifo_cnt_n = fifo_cnt_q;
        unique case ({push_c, pop_c})
            2'b10:   fifo_cnt_n = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_n = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_n = fifo_cnt_q;
        endcase
        remain_c = fifo_cnt_q - CNT_W'(pop_c);
        if (fifo_cnt_n == '0) begin
            head_n = '0;
        end else if (remain_c == '0) begin
            // FIFO drains to empty this cycle, so the new head is the push
            head_n = push_entry_c;
        end else begin
            head_n = fifo_mem[rd_ptr_n];
        end
        free_count_n = free_count_q - CNT_W'(grant_c) + CNT_W'(pop_c) + CNT_W'(abort_c);
    end

    // Completion FIFO storage; contents are only read behind a valid count
    always_ff @(posedge sys_clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= push_entry_c;
        end
    end

    // Engine FSM, slot states, FIFO pointers and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < int'(SLOTS); i++) begin
                slot_q[i] <= SLOT_FREE;
            end
            eng_grant_q  <= 1'b0;
            eng_slot_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            host_valid_q <= 1'b0;
            host_slot_q  <= '0;
            host_count_q <= '0;
            free_count_q <= CNT_W'(SLOTS);
        end else begin
            unique case (state_q)
                ST_IDLE: if (grant_c)            state_q <= ST_OWN;
                ST_OWN:  if (abort_c || push_c)  state_q <= ST_IDLE;
                default:                         state_q <= ST_IDLE;
            endcase

            eng_grant_q <= grant_c;
            if (grant_c) begin
                eng_slot_q          <= free_idx_c;
                slot_q[free_idx_c]  <= SLOT_OWNED;
            end
            // The slots touched below are always distinct from the granted one
            if (abort_c) begin
                slot_q[eng_slot_q] <= SLOT_FREE;
            end
            if (push_c) begin
                slot_q[eng_slot_q] <= SLOT_QUEUED;
            end
            if (pop_c) begin
                slot_q[host_slot_q] <= SLOT_FREE;
            end

            rd_ptr_q     <= rd_ptr_n;
            wr_ptr_q     <= wr_ptr_n;
            fifo_cnt_q   <= fifo_cnt_n;
            host_valid_q <= (fifo_cnt_n != '0);
            host_slot_q  <= head_n.slot;
            host_count_q <= head_n.count;
            free_count_q <= free_count_n;
        end
    end

`ifdef MINIMAC3_RXQ_STATS_EN
    logic        drop_c;
    logic [15:0] drop_cnt_q;

    // Request refused for lack of a FREE slot
    always_comb begin
        drop_c = (state_q == ST_IDLE) && bus.eng_req && (free_count_q == '0);
    end

    // Saturating drop counter
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = 16'd0;
`endif

    assign bus.eng_grant  = eng_grant_q;
    assign bus.eng_slot   = eng_slot_q;
    assign bus.host_valid = host_valid_q;
    assign bus.host_slot  = host_slot_q;
    assign bus.host_count = host_count_q;
    assign bus.irq_rx     = host_valid_q;
    assign bus.free_count = free_count_q;

endmodule

// File: tb/tb_minimac3_rxq.sv
// tb_minimac3_rxq: scenario bench for the receive slot queue with a
// scoreboard of expected host-side frames.
module tb_minimac3_rxq;

    localparam int unsigned SLOTS   = 4;
    localparam int unsigned COUNT_W = 11;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned OW      = 1 + IDX_W + 1 + IDX_W + COUNT_W + 1 + (IDX_W + 1) + 16;

`ifdef MINIMAC3_RXQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [OW-1:0] RST_OUTS = {1'b0, IDX_W'(0), 1'b0, IDX_W'(0), COUNT_W'(0),
                                          1'b0, (IDX_W + 1)'(SLOTS), 16'd0};

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    minimac3_rxq_if #(.IDX_W(IDX_W), .COUNT_W(COUNT_W)) bus ();

    minimac3_rxq #(.SLOTS(SLOTS), .COUNT_W(COUNT_W), .IDX_W(IDX_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int slot;
        int count;
    } exp_t;

    exp_t sb[$];
    bit   m_free [SLOTS];
    int   m_drop;
    int   checks;
    int   errors;

    function automatic logic [OW-1:0] outs();
        return {bus.eng_grant, bus.eng_slot, bus.host_valid, bus.host_slot, bus.host_count,
                bus.irq_rx, bus.free_count, bus.drop_cnt};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(SLOTS); i++) m_free[i] = 1'b1;
        sb.delete();
        m_drop = 0;
    endtask

    // Reference allocator: lowest free slot, -1 when none
    task automatic model_alloc(output int s);
        s = -1;
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (s < 0 && m_free[i]) s = i;
        end
        if (s >= 0) m_free[s] = 1'b0;
        else if (STATS && m_drop < 65535) m_drop++;
    endtask

    task automatic req_pulse();
        bus.eng_req = 1'b1;
        tick();
        bus.eng_req = 1'b0;
    endtask

    task automatic done_pulse(input int slot, input int cnt);
        bus.eng_done  = 1'b1;
        bus.eng_count = COUNT_W'(cnt);
        sb.push_back('{slot: slot, count: cnt});
        tick();
        bus.eng_done  = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.host_ack = 1'b1;
        tick();
        bus.host_ack = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #12;
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), RST_OUTS);
        end
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        tick();
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", outs(), RST_OUTS);
        end
    endtask

    task automatic test_grant_complete();
        int   s;
        exp_t e;
        model_alloc(s);
        req_pulse();
        checks++;
        if (bus.eng_grant !== 1'b1 || bus.eng_slot !== IDX_W'(s) || bus.free_count !== 3'd3) begin
            errors++;
            $display("FAIL gc_grant: got grant=%0b slot=%0d free=%0d expected 1 %0d 3",
                     bus.eng_grant, bus.eng_slot, bus.free_count, s);
        end
        tick();
        checks++;
        if (bus.eng_grant !== 1'b0) begin
            errors++;
            $display("FAIL gc_grant_pulse: got %0b expected 0", bus.eng_grant);
        end
        done_pulse(s, 64);
        e = sb[0];
        checks++;
        if (bus.host_valid !== 1'b1 || bus.irq_rx !== 1'b1 || bus.host_slot !== IDX_W'(e.slot) ||
            bus.host_count !== COUNT_W'(e.count) || bus.free_count !== 3'd3) begin
            errors++;
            $display("FAIL gc_queued: got v=%0b irq=%0b slot=%0d cnt=%0d free=%0d expected 1 1 %0d %0d 3",
                     bus.host_valid, bus.irq_rx, bus.host_slot, bus.host_count, bus.free_count,
                     e.slot, e.count);
        end
        void'(sb.pop_front());
        m_free[e.slot] = 1'b1;
        ack_pulse();
        checks++;
        if (bus.host_valid !== 1'b0 || bus.irq_rx !== 1'b0 || bus.free_count !== 3'd4) begin
            errors++;
            $display("FAIL gc_released: got v=%0b irq=%0b free=%0d expected 0 0 4",
                     bus.host_valid, bus.irq_rx, bus.free_count);
        end
    endtask

    task automatic test_exhaustion();
        int   s;
        exp_t e;
        for (int k = 0; k < int'(SLOTS); k++) begin
            model_alloc(s);
            req_pulse();
            checks++;
            if (bus.eng_grant !== 1'b1 || bus.eng_slot !== IDX_W'(s)) begin
                errors++;
                $display("FAIL ex_fill_grant%0d: got grant=%0b slot=%0d expected 1 %0d",
                         k, bus.eng_grant, bus.eng_slot, s);
            end
            done_pulse(s, 200 + k);
        end
        model_alloc(s);
        req_pulse();
        checks++;
        if (bus.eng_grant !== 1'b0 || bus.drop_cnt !== 16'(m_drop) || bus.free_count !== 3'd0) begin
            errors++;
            $display("FAIL ex_drop: got grant=%0b drop=%0d free=%0d expected 0 %0d 0",
                     bus.eng_grant, bus.drop_cnt, bus.free_count, m_drop);
        end
        e = sb.pop_front();
        checks++;
        if (bus.host_valid !== 1'b1 || bus.host_slot !== IDX_W'(e.slot) ||
            bus.host_count !== COUNT_W'(e.count)) begin
            errors++;
            $display("FAIL ex_head: got v=%0b slot=%0d cnt=%0d expected 1 %0d %0d",
                     bus.host_valid, bus.host_slot, bus.host_count, e.slot, e.count);
        end
        m_free[e.slot] = 1'b1;
        ack_pulse();
        model_alloc(s);
        req_pulse();
        checks++;
        if (bus.eng_grant !== 1'b1 || bus.eng_slot !== IDX_W'(s) || s != 0) begin
            errors++;
            $display("FAIL ex_regrant: got grant=%0b slot=%0d expected 1 0", bus.eng_grant, bus.eng_slot);
        end
        done_pulse(s, 300);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.host_valid !== 1'b1 || bus.host_slot !== IDX_W'(e.slot) ||
                bus.host_count !== COUNT_W'(e.count)) begin
                errors++;
                $display("FAIL ex_drain: got v=%0b slot=%0d cnt=%0d expected 1 %0d %0d",
                         bus.host_valid, bus.host_slot, bus.host_count, e.slot, e.count);
            end
            m_free[e.slot] = 1'b1;
            ack_pulse();
        end
        checks++;
        if (bus.host_valid !== 1'b0 || bus.free_count !== 3'd4) begin
            errors++;
            $display("FAIL ex_empty: got v=%0b free=%0d expected 0 4", bus.host_valid, bus.free_count);
        end
    endtask

    task automatic test_ordering();
        int   s;
        exp_t e;
        int   cnts [3];
        cnts[0] = 60;
        cnts[1] = 1514;
        cnts[2] = 100;
        for (int k = 0; k < 3; k++) begin
            model_alloc(s);
            req_pulse();
            checks++;
            if (bus.eng_grant !== 1'b1 || bus.eng_slot !== IDX_W'(k)) begin
                errors++;
                $display("FAIL ord_grant%0d: got grant=%0b slot=%0d expected 1 %0d",
                         k, bus.eng_grant, bus.eng_slot, k);
            end
            done_pulse(s, cnts[k]);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.host_valid !== 1'b1 || bus.host_slot !== IDX_W'(e.slot) ||
                bus.host_count !== COUNT_W'(e.count)) begin
                errors++;
                $display("FAIL ord_head: got v=%0b slot=%0d cnt=%0d expected 1 %0d %0d",
                         bus.host_valid, bus.host_slot, bus.host_count, e.slot, e.count);
            end
            m_free[e.slot] = 1'b1;
            ack_pulse();
        end
        checks++;
        if (bus.host_valid !== 1'b0 || bus.irq_rx !== 1'b0) begin
            errors++;
            $display("FAIL ord_empty: got v=%0b irq=%0b expected 0 0", bus.host_valid, bus.irq_rx);
        end
        ack_pulse();
        checks++;
        if (bus.host_valid !== 1'b0 || bus.free_count !== 3'd4) begin
            errors++;
            $display("FAIL ord_idle_ack: got v=%0b free=%0d expected 0 4", bus.host_valid, bus.free_count);
        end
    endtask

    task automatic test_abort();
        int s;
        model_alloc(s);
        req_pulse();
        req_pulse();
        checks++;
        if (bus.eng_grant !== 1'b0 || bus.drop_cnt !== 16'(m_drop) || bus.free_count !== 3'd3) begin
            errors++;
            $display("FAIL ab_req_in_own: got grant=%0b drop=%0d free=%0d expected 0 %0d 3",
                     bus.eng_grant, bus.drop_cnt, bus.free_count, m_drop);
        end
        bus.eng_done  = 1'b1;
        bus.eng_abort = 1'b1;
        bus.eng_count = COUNT_W'(77);
        tick();
        bus.eng_done  = 1'b0;
        bus.eng_abort = 1'b0;
        m_free[s] = 1'b1;
        tick();
        checks++;
        if (bus.host_valid !== 1'b0 || bus.free_count !== 3'd4) begin
            errors++;
            $display("FAIL ab_done_abort: got v=%0b free=%0d expected 0 4", bus.host_valid, bus.free_count);
        end
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        tick();
        checks++;
        if (bus.host_valid !== 1'b0 || bus.free_count !== 3'd4) begin
            errors++;
            $display("FAIL ab_done_idle: got v=%0b free=%0d expected 0 4", bus.host_valid, bus.free_count);
        end
        model_alloc(s);
        req_pulse();
        checks++;
        if (bus.eng_grant !== 1'b1 || bus.eng_slot !== IDX_W'(s) || s != 0) begin
            errors++;
            $display("FAIL ab_regrant: got grant=%0b slot=%0d expected 1 0", bus.eng_grant, bus.eng_slot);
        end
        bus.eng_abort = 1'b1;
        tick();
        bus.eng_abort = 1'b0;
        m_free[s] = 1'b1;
        checks++;
        if (bus.free_count !== 3'd4 || bus.host_valid !== 1'b0) begin
            errors++;
            $display("FAIL ab_abort_only: got free=%0d v=%0b expected 4 0", bus.free_count, bus.host_valid);
        end
    endtask

    task automatic test_simultaneous();
        int   s;
        exp_t e;
        model_alloc(s);
        req_pulse();
        done_pulse(s, 10);
        model_alloc(s);
        req_pulse();
        done_pulse(s, 20);
        model_alloc(s);
        req_pulse();
        checks++;
        if (bus.free_count !== 3'd1 || bus.host_slot !== 2'd0 || bus.host_count !== 11'd10) begin
            errors++;
            $display("FAIL sim_setup: got free=%0d slot=%0d cnt=%0d expected 1 0 10",
                     bus.free_count, bus.host_slot, bus.host_count);
        end
        e = sb.pop_front();
        m_free[e.slot] = 1'b1;
        bus.host_ack = 1'b1;
        done_pulse(s, 30);
        bus.host_ack = 1'b0;
        e = sb[0];
        checks++;
        if (bus.host_valid !== 1'b1 || bus.host_slot !== IDX_W'(e.slot) ||
            bus.host_count !== COUNT_W'(e.count) || bus.free_count !== 3'd2) begin
            errors++;
            $display("FAIL sim_push_pop: got v=%0b slot=%0d cnt=%0d free=%0d expected 1 %0d %0d 2",
                     bus.host_valid, bus.host_slot, bus.host_count, bus.free_count, e.slot, e.count);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.host_valid !== 1'b1 || bus.host_slot !== IDX_W'(e.slot) ||
                bus.host_count !== COUNT_W'(e.count)) begin
                errors++;
                $display("FAIL sim_drain: got v=%0b slot=%0d cnt=%0d expected 1 %0d %0d",
                         bus.host_valid, bus.host_slot, bus.host_count, e.slot, e.count);
            end
            m_free[e.slot] = 1'b1;
            ack_pulse();
        end
        checks++;
        if (bus.host_valid !== 1'b0 || bus.free_count !== 3'd4) begin
            errors++;
            $display("FAIL sim_occupancy: got v=%0b free=%0d expected 0 4", bus.host_valid, bus.free_count);
        end
    endtask

    task automatic test_reset_mid_own();
        int s;
        model_alloc(s);
        req_pulse();
        done_pulse(s, 55);
        model_alloc(s);
        req_pulse();
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL rst_async: got %h expected %h", outs(), RST_OUTS);
        end
        model_reset();
        tick();
        sys_rst_n = 1'b1;
        tick();
        checks++;
        if (outs() !== RST_OUTS) begin
            errors++;
            $display("FAIL rst_no_survivor: got %h expected %h", outs(), RST_OUTS);
        end
        model_alloc(s);
        req_pulse();
        checks++;
        if (bus.eng_grant !== 1'b1 || bus.eng_slot !== IDX_W'(s) || s != 0 || bus.free_count !== 3'd3) begin
            errors++;
            $display("FAIL rst_regrant: got grant=%0b slot=%0d free=%0d expected 1 0 3",
                     bus.eng_grant, bus.eng_slot, bus.free_count);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        bus.eng_req   = 1'b0;
        bus.eng_done  = 1'b0;
        bus.eng_count = '0;
        bus.eng_abort = 1'b0;
        bus.host_ack  = 1'b0;
        model_reset();

        test_reset();
        test_grant_complete();
        test_exhaustion();
        test_ordering();
        test_abort();
        test_simultaneous();
        test_reset_mid_own();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
